distortion_ctrl: RTL and testbench
==================================

Name: distortion_ctrl

Overview:
Control and sequencing block for the distortion effect.
- Converts raw push-button presses into a drive level (0..NUM_LEVELS-1) and converts the enable switch into wet/dry crossfade state.
- Ramps the soft/hard clip thresholds toward the per-level targets, one step per audio sample, so level changes do not click.
- Drives the threshold and wet-gain inputs of the distortion datapath. It sits between the board I/O (SW/KEY) and the audio effect chain, timed by the codec sample strobe.

Parameters:
NUM_LEVELS, 8, number of drive levels; level L gives target soft = BASE_SOFT >>> L, hard = 2*soft.
BASE_SOFT, 15000000, level-0 soft threshold (least distortion); hard target at level 0 = 30000000.
RAMP_STEP, 250000, maximum threshold change per sample_tick.
XFADE_LOG2, 8, crossfade length = 2^XFADE_LOG2 samples.
DEBOUNCE_CYC, 500000, consecutive stable cycles (10 ms at 50 MHz) to accept a key press.

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
resetn  input  1  asynchronous active-low reset.
sample_tick  input  1  one-cycle strobe per audio sample (codec read/write ready).
enable_sw  input  1  raw effect-enable switch (SW); asynchronous.
key_up  input  1  raw KEY, active-low, asynchronous; increases drive.
key_dn  input  1  raw KEY, active-low, asynchronous; decreases drive.
soft_thresh  output  32  signed current soft threshold, always positive.
hard_thresh  output  32  signed current hard threshold, always positive.
wet_gain  output  XFADE_LOG2+1  wet mix weight, 0..2^XFADE_LOG2; dry weight = 2^XFADE_LOG2 - wet_gain.
level  output  $clog2(NUM_LEVELS)  current target drive level.
busy  output  1  high while a threshold ramp or crossfade is in progress.

Behaviour:
- Clock and reset:
  - All state clocks on CLOCK_50 rising edge.
  - resetn low asynchronously forces: level=0, soft_thresh=15000000, hard_thresh=30000000, wet_gain=0, FSM=BYPASS, busy=0, debounce counters and synchronisers cleared.
  - Reset mid-ramp or mid-fade abandons the ramp or fade immediately.
- Input synchronisation: enable_sw, key_up and key_dn each pass through a 2-flop synchroniser before any use.
- Debounce:
  - Per key, a counter increments while the synchronised level is unchanged and resets on any change.
  - A press event is a single-cycle pulse generated when a key has been stable low for DEBOUNCE_CYC cycles.
  - Exactly one event per press; no auto-repeat. Release requires DEBOUNCE_CYC stable-high cycles before the next press is accepted.
- Level update:
  - Up event: level increments, saturating at NUM_LEVELS-1.
  - Down event: level decrements, saturating at 0.
  - Up and down events in the same cycle: both ignored, level unchanged.
  - Level updates immediately on the event; the targets follow combinationally from level.
- Threshold ramp: applies only on sample_tick cycles. For each threshold independently:
  - If |target - current| <= RAMP_STEP, current = target.
  - Otherwise current moves toward target by exactly RAMP_STEP; it never overshoots.
  - A level change mid-ramp retargets from the current value with no jump.
  - Arithmetic is 33-bit signed internally; outputs never exceed the level-0 values or drop below the level-(NUM_LEVELS-1) values.
- Crossfade FSM: state changes occur on sample_tick only, except the flip of enable_sw itself, which is evaluated every cycle.
  - BYPASS: wet_gain=0. Synchronised enable_sw=1 -> FADE_IN.
  - FADE_IN: wet_gain +1 per tick. Reaching 2^XFADE_LOG2 -> ACTIVE. enable_sw=0 -> FADE_OUT, continuing from the current wet_gain with no jump.
  - ACTIVE: wet_gain=2^XFADE_LOG2. enable_sw=0 -> FADE_OUT.
  - FADE_OUT: wet_gain -1 per tick. Reaching 0 -> BYPASS. enable_sw=1 -> FADE_IN.
- busy = (FSM in FADE_IN or FADE_OUT) OR (soft_thresh != target) OR (hard_thresh != target). busy is registered.
- No sample_tick: thresholds and wet_gain hold. Key events are still accepted.
- Latency:
  - Key: stable press to level change = 2 sync + DEBOUNCE_CYC + 1 cycles.
  - Thresholds and wet_gain update on the cycle after sample_tick.

Optional Feature:
Macro DISTORTION_CTRL_WRAP_EN.
- Defined: up event at NUM_LEVELS-1 wraps level to 0; down event at 0 wraps to NUM_LEVELS-1. The thresholds then ramp across the full range.
- Undefined: level saturates at both ends as described in Behaviour.

Test Plan:
Bench setup for all scenarios: DEBOUNCE_CYC=4, RAMP_STEP=250000, XFADE_LOG2=3, sample_tick every 8 cycles.
- Reset: assert resetn low mid-operation -> next cycle soft_thresh=15000000, hard_thresh=30000000, wet_gain=0, level=0, busy=0.
- Key up: hold key_up low 10 cycles -> exactly one event, level=1; targets 7500000/15000000. soft_thresh falls by 250000 per tick and reaches 7500000 after 30 ticks; busy then drops.
- Bounce: toggle key_up every 2 cycles for 20 cycles, then release -> level unchanged. Hold key_up low with level already 7 -> level stays 7 (macro undefined) or becomes 0 (macro defined).
- Simultaneous keys: key_up and key_dn low on the same cycle, both held 10 cycles -> level unchanged.
- Crossfade: enable_sw 0->1 -> wet_gain 0,1,...,8 on successive ticks, then ACTIVE. Drop enable_sw at wet_gain=5 -> wet_gain 4,3,2,1,0, then BYPASS, busy=0.
- Retarget: from level 0, press up three times quickly -> thresholds ramp monotonically toward 1875000/3750000 with no step larger than 250000.

Source files
------------

// File: rtl/distortion_ctrl.sv
// Distortion effect control: key debounce to drive level, per-sample threshold ramping,
// and wet/dry crossfade FSM. Optional macro DISTORTION_CTRL_WRAP_EN makes the level wrap at both ends.
module distortion_ctrl #(
    parameter int NUM_LEVELS   = 8,
    parameter int BASE_SOFT    = 15000000,
    parameter int RAMP_STEP    = 250000,
    parameter int XFADE_LOG2   = 8,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          sample_tick,
    input  logic                          enable_sw,
    input  logic                          key_up,
    input  logic                          key_dn,
    output logic [31:0]                   soft_thresh,
    output logic [31:0]                   hard_thresh,
    output logic [XFADE_LOG2:0]           wet_gain,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic                          busy
);

    localparam int LW = $clog2(NUM_LEVELS);
    localparam int WW = XFADE_LOG2 + 1;
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [LW-1:0]        LMAX     = LW'(NUM_LEVELS - 1);
    localparam logic [WW-1:0]        FULL     = WW'(1) << XFADE_LOG2;
    localparam logic [WW-1:0]        FULL_M1  = FULL - WW'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic signed [32:0]   BASE_S   = 33'(BASE_SOFT);
    localparam logic signed [32:0]   STEP_S   = 33'(RAMP_STEP);

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        FADE_IN  = 2'd1,
        ACTIVE   = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    // Synchroniser bit 0 = enable_sw, bit 1 = key_up, bit 2 = key_dn.
    logic [2:0]          sync1_q, sync2_q;
    logic                en_s;
    logic [1:0]          key_s;
    logic [1:0]          db_q;
    logic [CW-1:0]       cnt_q [2];
    logic [1:0]          evt_q;

    logic [LW-1:0]       level_q, level_d;
    logic signed [32:0]  soft_q, soft_d, hard_q, hard_d;
    logic signed [32:0]  tgt_soft, tgt_hard, tgt_soft_n, tgt_hard_n;
    fade_state_t         state_q, state_d;
    logic [WW-1:0]       wet_q, wet_d;
    logic                busy_q, busy_d;

    assign en_s  = sync2_q[0];
    assign key_s = sync2_q[2:1];

    // Keys idle high, so their synchroniser and debounced state reset to the released level.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 3'b110;
            sync2_q <= 3'b110;
            db_q    <= 2'b11;
            evt_q   <= 2'b00;
            for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
        end else begin
            sync1_q <= {key_dn, key_up, enable_sw};
            sync2_q <= sync1_q;
            for (int k = 0; k < 2; k++) begin
                if (key_s[k] == db_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    cnt_q[k] <= '0;
                    db_q[k]  <= key_s[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + CW'(1);
                end
                evt_q[k] <= (key_s[k] != db_q[k]) && (cnt_q[k] == CNT_LAST) && !key_s[k];
            end
        end
    end

    always_comb begin
        level_d = level_q;
        if (evt_q[0] && !evt_q[1]) begin
            if (level_q == LMAX) begin
`ifdef DISTORTION_CTRL_WRAP_EN
                level_d = '0;
`else
                level_d = LMAX;
`endif
            end else begin
                level_d = level_q + LW'(1);
            end
        end else if (evt_q[1] && !evt_q[0]) begin
            if (level_q == '0) begin
`ifdef DISTORTION_CTRL_WRAP_EN
                level_d = LMAX;
`else
                level_d = '0;
`endif
            end else begin
                level_d = level_q - LW'(1);
            end
        end
    end

    function automatic logic signed [32:0] ramp_to(input logic signed [32:0] cur,
                                                   input logic signed [32:0] tgt);
        logic signed [32:0] diff;
        diff = tgt - cur;
        if (diff > STEP_S)       ramp_to = cur + STEP_S;
        else if (diff < -STEP_S) ramp_to = cur - STEP_S;
        else                     ramp_to = tgt;
    endfunction

    // Ramp follows the committed level; busy looks at the level being written this cycle.
    always_comb begin
        tgt_soft   = BASE_S >>> level_q;
        tgt_hard   = tgt_soft <<< 1;
        tgt_soft_n = BASE_S >>> level_d;
        tgt_hard_n = tgt_soft_n <<< 1;
        soft_d     = sample_tick ? ramp_to(soft_q, tgt_soft) : soft_q;
        hard_d     = sample_tick ? ramp_to(hard_q, tgt_hard) : hard_q;
    end

    // The enable flip retargets the fade on any cycle; gain only moves on sample ticks.
    always_comb begin
        state_d = state_q;
        wet_d   = wet_q;
        case (state_q)
            BYPASS: begin
                wet_d = '0;
                if (en_s) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (!en_s) begin
                    state_d = FADE_OUT;
                end else if (sample_tick) begin
                    if (wet_q >= FULL_M1) begin
                        wet_d   = FULL;
                        state_d = ACTIVE;
                    end else begin
                        wet_d = wet_q + WW'(1);
                    end
                end
            end
            ACTIVE: begin
                wet_d = FULL;
                if (!en_s) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (en_s) begin
                    state_d = FADE_IN;
                end else if (sample_tick) begin
                    if (wet_q <= WW'(1)) begin
                        wet_d   = '0;
                        state_d = BYPASS;
                    end else begin
                        wet_d = wet_q - WW'(1);
                    end
                end
            end
            default: begin
                state_d = BYPASS;
                wet_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT) ||
                 (soft_d != tgt_soft_n) || (hard_d != tgt_hard_n);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            level_q <= '0;
            soft_q  <= BASE_S;
            hard_q  <= BASE_S <<< 1;
            state_q <= BYPASS;
            wet_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            soft_q  <= soft_d;
            hard_q  <= hard_d;
            state_q <= state_d;
            wet_q   <= wet_d;
            busy_q  <= busy_d;
        end
    end

    assign soft_thresh = soft_q[31:0];
    assign hard_thresh = hard_q[31:0];
    assign wet_gain    = wet_q;
    assign level       = level_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_distortion_ctrl.sv
// Bench for distortion_ctrl: key presses, threshold ramps, crossfade and reset, checked
// against expected values queued when the stimulus is driven.
module tb_distortion_ctrl;

    localparam int NL   = 8;
    localparam int DEB  = 4;
    localparam int STEP = 250000;
    localparam int XL   = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_tick = 1'b0;
    logic          enable_sw = 1'b0;
    logic          key_up = 1'b1;
    logic          key_dn = 1'b1;
    logic [31:0]   soft_thresh;
    logic [31:0]   hard_thresh;
    logic [XL:0]   wet_gain;
    logic [2:0]    level;
    logic          busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;

    distortion_ctrl #(
        .NUM_LEVELS  (NL),
        .BASE_SOFT   (15000000),
        .RAMP_STEP   (STEP),
        .XFADE_LOG2  (XL),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .sample_tick(sample_tick),
        .enable_sw  (enable_sw),
        .key_up     (key_up),
        .key_dn     (key_dn),
        .soft_thresh(soft_thresh),
        .hard_thresh(hard_thresh),
        .wet_gain   (wet_gain),
        .level      (level),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One audio sample period: seven idle cycles then a one-cycle strobe.
    task automatic tick();
        cycles(7);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        if (up) key_up = 1'b0;
        if (dn) key_dn = 1'b0;
        cycles(hold);
        key_up = 1'b1;
        key_dn = 1'b1;
        cycles(8);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_soft"},  soft_thresh, 32'd15000000);
        check({tag, "_hard"},  hard_thresh, 32'd30000000);
        check({tag, "_wet"},   32'(wet_gain), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic tick_check_thresh(input string tag);
        tick();
        check({tag, "_soft"}, soft_thresh, exp_q.pop_front());
        check({tag, "_hard"}, hard_thresh, exp_q.pop_front());
    endtask

    task automatic tick_check_wet(input string tag);
        tick();
        check(tag, 32'(wet_gain), exp_q.pop_front());
    endtask

    // Downward-only ramp reference for the retarget scenario.
    int cur_s, cur_h, ex_lvl;
    task automatic model_tick();
        int ts, th;
        ts = 15000000 >> ex_lvl;
        th = 2 * ts;
        cur_s = (cur_s - ts > STEP) ? cur_s - STEP : ts;
        cur_h = (cur_h - th > STEP) ? cur_h - STEP : th;
        exp_q.push_back(32'(cur_s));
        exp_q.push_back(32'(cur_h));
    endtask

    task automatic retarget_tick();
        logic [31:0] ps, ph;
        ps = soft_thresh;
        ph = hard_thresh;
        model_tick();
        tick_check_thresh("retarget");
        check("retarget_soft_step", 32'((soft_thresh <= ps) && (ps - soft_thresh <= STEP)), 32'd1);
        check("retarget_hard_step", 32'((hard_thresh <= ph) && (ph - hard_thresh <= STEP)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, h, guard;

        cycles(3);
        check_reset("rst");
        resetn = 1'b1;
        cycles(4);
        check_reset("post_rst");

        // Single up press: one event, then a 30-tick soft ramp and 60-tick hard ramp.
        press(1'b1, 1'b0, 10);
        check("lvl_up", 32'(level), 32'd1);
        check("busy_up", 32'(busy), 32'd1);
        for (int n = 1; n <= 60; n++) begin
            s = 15000000 - n * STEP;
            h = 30000000 - n * STEP;
            if (s < 7500000)  s = 7500000;
            if (h < 15000000) h = 15000000;
            exp_q.push_back(32'(s));
            exp_q.push_back(32'(h));
        end
        for (int n = 0; n < 60; n++) tick_check_thresh("ramp1");
        check("busy_ramp_done", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            key_up = 1'b0;
            cycles(2);
            key_up = 1'b1;
            cycles(2);
        end
        cycles(8);
        check("bounce_level", 32'(level), 32'd1);

        press(1'b1, 1'b1, 10);
        check("simul_level", 32'(level), 32'd1);

        // Crossfade: full fade in, full fade out, then an interrupted fade in.
        enable_sw = 1'b1;
        cycles(3);
        check("fade_busy", 32'(busy), 32'd1);
        check("fade_wet0", 32'(wet_gain), 32'd0);
        for (int v = 1; v <= 8; v++) exp_q.push_back(32'(v));
        for (int v = 1; v <= 8; v++) tick_check_wet("fade_in");
        check("active_busy", 32'(busy), 32'd0);
        tick();
        check("active_hold", 32'(wet_gain), 32'd8);
        enable_sw = 1'b0;
        for (int v = 7; v >= 0; v--) exp_q.push_back(32'(v));
        for (int v = 0; v < 8; v++) tick_check_wet("fade_out");
        check("bypass_busy", 32'(busy), 32'd0);
        enable_sw = 1'b1;
        for (int v = 1; v <= 5; v++) exp_q.push_back(32'(v));
        for (int v = 0; v < 5; v++) tick_check_wet("fade_in2");
        enable_sw = 1'b0;
        for (int v = 4; v >= 0; v--) exp_q.push_back(32'(v));
        for (int v = 0; v < 5; v++) tick_check_wet("fade_out2");
        check("fade_out2_busy", 32'(busy), 32'd0);
        tick();
        check("bypass_hold", 32'(wet_gain), 32'd0);

        // Reset in the middle of a ramp.
        press(1'b1, 1'b0, 10);
        check("lvl_two", 32'(level), 32'd2);
        tick();
        tick();
        check("midramp_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        resetn = 1'b1;
        cycles(4);

        // Three quick presses retargeting an in-flight ramp.
        cur_s = 15000000;
        cur_h = 30000000;
        ex_lvl = 0;
        for (int p = 0; p < 3; p++) begin
            press(1'b1, 1'b0, 10);
            ex_lvl++;
            check("retarget_level", 32'(level), 32'(ex_lvl));
            if (p < 2) begin
                retarget_tick();
                retarget_tick();
            end
        end
        guard = 0;
        while (busy && guard < 200) begin
            retarget_tick();
            guard++;
        end
        check("retarget_timeout", 32'(guard < 200), 32'd1);
        check("retarget_soft_final", soft_thresh, 32'd1875000);
        check("retarget_hard_final", hard_thresh, 32'd3750000);
        check("retarget_busy", 32'(busy), 32'd0);

        for (int l = 4; l <= 7; l++) begin
            press(1'b1, 1'b0, 10);
            check("sat_climb", 32'(level), 32'(l));
        end
        press(1'b1, 1'b0, 10);
`ifdef DISTORTION_CTRL_WRAP_EN
        check("top_edge", 32'(level), 32'd0);
`else
        check("top_edge", 32'(level), 32'd7);
`endif

        resetn = 1'b0;
        cycles(2);
        resetn = 1'b1;
        cycles(4);
        press(1'b0, 1'b1, 10);
`ifdef DISTORTION_CTRL_WRAP_EN
        check("bottom_edge", 32'(level), 32'd7);
`else
        check("bottom_edge", 32'(level), 32'd0);
`endif
        press(1'b0, 1'b1, 10);
`ifdef DISTORTION_CTRL_WRAP_EN
        check("down_step", 32'(level), 32'd6);
`else
        check("down_step", 32'(level), 32'd0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
